// File: rtl/mem_pkg.sv
// mem_pkg: shared encodings for the RAM arbiter.
//   MNONE/MREAD/MWRITE  CPU memory command codes
//   state_e             arbiter FSM states
//   OWN_CPU/OWN_LDR     requester identifiers (also the rr_pick2 request index)
package mem_pkg;

  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ISSUE = 2'b01,
    S_RESP  = 2'b10
  } state_e;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_LDR = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// rr_pick2: combinational two-way round-robin picker.
//   req[1:0]  request vector, index OWN_CPU / OWN_LDR
//   last      requester granted most recently
//   grant     winning requester index (meaningful when valid=1)
//   valid     at least one request present
module rr_pick2
  import mem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant,
  output logic       valid
);

  assign valid = |req;

  always_comb begin
    grant = OWN_CPU;
    case (req)
      2'b01:   grant = OWN_CPU;
      2'b10:   grant = OWN_LDR;
      2'b11:   grant = ~last;
      default: grant = OWN_CPU;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous-read RAM between the CPU port and the
// loader port, one outstanding access at a time, two-way round-robin.
//   clk, reset                   clock, synchronous active-high reset
//   cpu_cmd/addr/wdata           CPU command (held while cpu_wait=1)
//   cpu_rdata, cpu_wait          CPU read data / stall
//   ldr_req/we/addr/wdata        loader request (held until ldr_ack)
//   ldr_ack, ldr_rdata           loader completion pulse / read data
//   ram_addr/we/din, ram_dout    RAM port (read data one cycle after address)
// Address bit ADDR_W-1 set means outside the RAM: writes are dropped and
// reads return zero, with unchanged handshake timing.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 9,
  parameter int RAM_AW = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        cpu_cmd,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_wait,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_ack,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  state_e state, state_nx;
  logic   owner, owner_nx;
  logic   last, last_nx;

  logic              cpu_act;
  logic              req_cpu, req_ldr;
  logic              grant, grant_vld;
  logic              arb_en;
  logic              in_resp_cpu, in_resp_ldr;
  logic              own_write, own_oor;
  logic [ADDR_W-1:0] own_addr;
  logic [DATA_W-1:0] own_wdata;
  logic [DATA_W-1:0] rd_word;

  assign cpu_act     = (cpu_cmd != MNONE);
  assign arb_en      = (state == S_IDLE) || (state == S_RESP);
  assign in_resp_cpu = (state == S_RESP) && (owner == OWN_CPU);
  assign in_resp_ldr = (state == S_RESP) && (owner == OWN_LDR);

  // The owner completing in RESP still holds its request; mask it so the
  // other side can be granted back-to-back.
  assign req_cpu = arb_en && cpu_act && !in_resp_cpu;
  assign req_ldr = arb_en && ldr_req && !in_resp_ldr;

  rr_pick2 u_pick (
    .req   ({req_ldr, req_cpu}),
    .last  (last),
    .grant (grant),
    .valid (grant_vld)
  );

  // Requesters hold address/data through RESP, so the owner's live inputs
  // drive both the ISSUE cycle and the read-data zeroing in RESP.
  always_comb begin
    own_addr  = cpu_addr;
    own_wdata = cpu_wdata;
    own_write = (cpu_cmd == MWRITE);
    if (owner == OWN_LDR) begin
      own_addr  = ldr_addr;
      own_wdata = ldr_wdata;
      own_write = ldr_we;
    end
  end

  assign own_oor = own_addr[ADDR_W-1];
  assign rd_word = own_oor ? '0 : ram_dout;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      owner <= OWN_CPU;
      last  <= OWN_LDR;
    end else begin
      state <= state_nx;
      owner <= owner_nx;
      last  <= last_nx;
    end
  end

  always_comb begin
    state_nx = S_IDLE;
    owner_nx = owner;
    last_nx  = last;
    case (state)
      S_IDLE, S_RESP: begin
        if (grant_vld) begin
          state_nx = S_ISSUE;
          owner_nx = grant;
          last_nx  = grant;
        end
      end
      S_ISSUE: state_nx = S_RESP;
      default: state_nx = S_IDLE;
    endcase
  end

  // Reset gates the write strobe directly so an ISSUE write in the reset
  // cycle never reaches the RAM.
  assign ram_we    = (state == S_ISSUE) && own_write && !own_oor && !reset;
  assign ram_addr  = (state == S_ISSUE) ? own_addr[RAM_AW-1:0] : '0;
  assign ram_din   = (state == S_ISSUE) ? own_wdata : '0;

  assign cpu_rdata = in_resp_cpu ? rd_word : '0;
  assign ldr_ack   = in_resp_ldr;
  assign ldr_rdata = in_resp_ldr ? rd_word : '0;
  assign cpu_wait  = cpu_act && !in_resp_cpu;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  import mem_pkg::*;

  logic        clk;
  logic        reset;
  logic [1:0]  cpu_cmd;
  logic [8:0]  cpu_addr;
  logic [15:0] cpu_wdata;
  logic [15:0] cpu_rdata;
  logic        cpu_wait;
  logic        ldr_req;
  logic        ldr_we;
  logic [8:0]  ldr_addr;
  logic [15:0] ldr_wdata;
  logic        ldr_ack;
  logic [15:0] ldr_rdata;
  logic [7:0]  ram_addr;
  logic        ram_we;
  logic [15:0] ram_din;
  logic [15:0] ram_dout;

  int checks;
  int errors;

  // Bench RAM model with a preload port
  logic [15:0] mem [256];
  logic        pre_we;
  logic [7:0]  pre_a;
  logic [15:0] pre_d;

  always @(posedge clk) begin
    if (pre_we) mem[pre_a] <= pre_d;
    else if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  mem_arbiter #(.DATA_W(16), .ADDR_W(9), .RAM_AW(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_cmd   (cpu_cmd),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_wait  (cpu_wait),
    .ldr_req   (ldr_req),
    .ldr_we    (ldr_we),
    .ldr_addr  (ldr_addr),
    .ldr_wdata (ldr_wdata),
    .ldr_ack   (ldr_ack),
    .ldr_rdata (ldr_rdata),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic preload(input logic [7:0] a, input logic [15:0] d);
    pre_we = 1'b1; pre_a = a; pre_d = d;
    tick();
    pre_we = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    smp();
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL rst_we got %b exp 0", ram_we); end
    checks++; if (ram_addr !== 8'h00) begin errors++; $display("FAIL rst_addr got %h exp 00", ram_addr); end
    checks++; if (ldr_ack !== 1'b0) begin errors++; $display("FAIL rst_ack got %b exp 0", ldr_ack); end
    checks++; if (cpu_wait !== 1'b0) begin errors++; $display("FAIL rst_wait_idle got %b exp 0", cpu_wait); end
    tick(); cpu_cmd = MREAD; cpu_addr = 9'h012;
    smp();
    checks++; if (cpu_wait !== 1'b1) begin errors++; $display("FAIL rst_wait_cmd got %b exp 1", cpu_wait); end
    tick(); cpu_cmd = MNONE; reset = 1'b0;
    smp();
    checks++; if (ram_addr !== 8'h00) begin errors++; $display("FAIL rst_release_addr got %h exp 00", ram_addr); end
  endtask

  task automatic test_cpu_read();
    tick(); cpu_cmd = MREAD; cpu_addr = 9'h012;
    smp();
    checks++; if (cpu_wait !== 1'b1) begin errors++; $display("FAIL rd_wait_t0 got %b exp 1", cpu_wait); end
    tick(); smp();
    checks++; if (cpu_wait !== 1'b1) begin errors++; $display("FAIL rd_wait_t1 got %b exp 1", cpu_wait); end
    checks++; if (ram_addr !== 8'h12) begin errors++; $display("FAIL rd_addr got %h exp 12", ram_addr); end
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL rd_we got %b exp 0", ram_we); end
    tick(); smp();
    checks++; if (cpu_wait !== 1'b0) begin errors++; $display("FAIL rd_wait_t2 got %b exp 0", cpu_wait); end
    checks++; if (cpu_rdata !== 16'hBEEF) begin errors++; $display("FAIL rd_data got %h exp beef", cpu_rdata); end
    tick(); cpu_cmd = MNONE;
    smp();
    checks++; if (cpu_rdata !== 16'h0000) begin errors++; $display("FAIL rd_data_after got %h exp 0000", cpu_rdata); end
  endtask

  task automatic test_ldr_wr_rd();
    tick(); ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 9'h005; ldr_wdata = 16'h1234;
    smp();
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL lw_we_t0 got %b exp 0", ram_we); end
    tick(); smp();
    checks++; if (ram_we !== 1'b1) begin errors++; $display("FAIL lw_we_issue got %b exp 1", ram_we); end
    checks++; if (ram_addr !== 8'h05) begin errors++; $display("FAIL lw_addr got %h exp 05", ram_addr); end
    checks++; if (ram_din !== 16'h1234) begin errors++; $display("FAIL lw_din got %h exp 1234", ram_din); end
    checks++; if (ldr_ack !== 1'b0) begin errors++; $display("FAIL lw_ack_early got %b exp 0", ldr_ack); end
    tick(); smp();
    checks++; if (ldr_ack !== 1'b1) begin errors++; $display("FAIL lw_ack got %b exp 1", ldr_ack); end
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL lw_we_resp got %b exp 0", ram_we); end
    tick(); ldr_we = 1'b0; ldr_wdata = 16'h0000;
    smp();
    checks++; if (ldr_ack !== 1'b0) begin errors++; $display("FAIL lr_ack_idle got %b exp 0", ldr_ack); end
    checks++; if (mem[5] !== 16'h1234) begin errors++; $display("FAIL lw_mem got %h exp 1234", mem[5]); end
    tick(); smp();
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL lr_we got %b exp 0", ram_we); end
    checks++; if (ram_addr !== 8'h05) begin errors++; $display("FAIL lr_addr got %h exp 05", ram_addr); end
    tick(); smp();
    checks++; if (ldr_ack !== 1'b1) begin errors++; $display("FAIL lr_ack got %b exp 1", ldr_ack); end
    checks++; if (ldr_rdata !== 16'h1234) begin errors++; $display("FAIL lr_data got %h exp 1234", ldr_rdata); end
    tick(); ldr_req = 1'b0;
    smp();
    checks++; if (ldr_ack !== 1'b0) begin errors++; $display("FAIL lr_ack_after got %b exp 0", ldr_ack); end
  endtask

  task automatic test_contention();
    tick(); reset = 1'b1;
    tick(); reset = 1'b0;
    cpu_cmd = MREAD; cpu_addr = 9'h030;
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 9'h040;
    smp();
    checks++; if (cpu_wait !== 1'b1) begin errors++; $display("FAIL tie_wait_t0 got %b exp 1", cpu_wait); end
    tick(); smp();
    checks++; if (ram_addr !== 8'h30) begin errors++; $display("FAIL tie_cpu_first got %h exp 30", ram_addr); end
    tick(); smp();
    checks++; if (cpu_wait !== 1'b0) begin errors++; $display("FAIL tie_cpu_done got %b exp 0", cpu_wait); end
    checks++; if (cpu_rdata !== 16'h3030) begin errors++; $display("FAIL tie_cpu_data got %h exp 3030", cpu_rdata); end
    checks++; if (ldr_ack !== 1'b0) begin errors++; $display("FAIL tie_ldr_early got %b exp 0", ldr_ack); end
    tick(); cpu_cmd = MNONE;
    smp();
    checks++; if (ram_addr !== 8'h40) begin errors++; $display("FAIL tie_ldr_issue got %h exp 40", ram_addr); end
    tick(); smp();
    checks++; if (ldr_ack !== 1'b1) begin errors++; $display("FAIL tie_ldr_ack got %b exp 1", ldr_ack); end
    checks++; if (ldr_rdata !== 16'h4040) begin errors++; $display("FAIL tie_ldr_data got %h exp 4040", ldr_rdata); end
    tick(); cpu_cmd = MREAD; cpu_addr = 9'h030;
    smp();
    checks++; if (ldr_ack !== 1'b0) begin errors++; $display("FAIL tie2_ack got %b exp 0", ldr_ack); end
    tick(); smp();
    checks++; if (ram_addr !== 8'h30) begin errors++; $display("FAIL tie2_cpu_wins got %h exp 30", ram_addr); end
    tick(); smp();
    checks++; if (cpu_wait !== 1'b0) begin errors++; $display("FAIL tie2_cpu_done got %b exp 0", cpu_wait); end
    tick(); cpu_cmd = MNONE;
    smp();
    checks++; if (ram_addr !== 8'h40) begin errors++; $display("FAIL tie2_ldr_issue got %h exp 40", ram_addr); end
    tick(); smp();
    checks++; if (ldr_ack !== 1'b1) begin errors++; $display("FAIL tie2_ldr_ack got %b exp 1", ldr_ack); end
    tick(); ldr_req = 1'b0;
    smp();
  endtask

  task automatic test_stream();
    tick(); reset = 1'b1;
    tick(); reset = 1'b0;
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 9'h050;
    smp();
    tick(); cpu_cmd = MWRITE; cpu_addr = 9'h020; cpu_wdata = 16'hA5A5;
    smp();
    checks++; if (ram_addr !== 8'h50) begin errors++; $display("FAIL st_ldr_issue got %h exp 50", ram_addr); end
    checks++; if (cpu_wait !== 1'b1) begin errors++; $display("FAIL st_wait_t1 got %b exp 1", cpu_wait); end
    tick(); smp();
    checks++; if (ldr_ack !== 1'b1) begin errors++; $display("FAIL st_ack1 got %b exp 1", ldr_ack); end
    checks++; if (ldr_rdata !== 16'h5050) begin errors++; $display("FAIL st_data1 got %h exp 5050", ldr_rdata); end
    checks++; if (cpu_wait !== 1'b1) begin errors++; $display("FAIL st_wait_t2 got %b exp 1", cpu_wait); end
    tick(); smp();
    checks++; if (ram_we !== 1'b1) begin errors++; $display("FAIL st_cpu_we got %b exp 1", ram_we); end
    checks++; if (ram_addr !== 8'h20) begin errors++; $display("FAIL st_cpu_addr got %h exp 20", ram_addr); end
    checks++; if (ram_din !== 16'hA5A5) begin errors++; $display("FAIL st_cpu_din got %h exp a5a5", ram_din); end
    tick(); smp();
    checks++; if (cpu_wait !== 1'b0) begin errors++; $display("FAIL st_cpu_done got %b exp 0", cpu_wait); end
    checks++; if (ldr_ack !== 1'b0) begin errors++; $display("FAIL st_ack_gap got %b exp 0", ldr_ack); end
    tick(); cpu_cmd = MNONE; cpu_wdata = 16'h0000;
    smp();
    checks++; if (ram_addr !== 8'h50) begin errors++; $display("FAIL st_ldr_issue2 got %h exp 50", ram_addr); end
    checks++; if (mem[8'h20] !== 16'hA5A5) begin errors++; $display("FAIL st_mem got %h exp a5a5", mem[8'h20]); end
    tick(); smp();
    checks++; if (ldr_ack !== 1'b1) begin errors++; $display("FAIL st_ack2 got %b exp 1", ldr_ack); end
    tick(); ldr_req = 1'b0;
    smp();
  endtask

  task automatic test_out_of_range();
    tick(); cpu_cmd = MWRITE; cpu_addr = 9'h100; cpu_wdata = 16'hFFFF;
    smp();
    checks++; if (cpu_wait !== 1'b1) begin errors++; $display("FAIL oor_wait_t0 got %b exp 1", cpu_wait); end
    tick(); smp();
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL oor_we got %b exp 0", ram_we); end
    checks++; if (cpu_wait !== 1'b1) begin errors++; $display("FAIL oor_wait_t1 got %b exp 1", cpu_wait); end
    tick(); smp();
    checks++; if (cpu_wait !== 1'b0) begin errors++; $display("FAIL oor_wr_done got %b exp 0", cpu_wait); end
    tick(); cpu_cmd = MREAD; cpu_wdata = 16'h0000;
    smp();
    tick(); smp();
    checks++; if (cpu_wait !== 1'b1) begin errors++; $display("FAIL oor_rd_wait got %b exp 1", cpu_wait); end
    checks++; if (ram_addr !== 8'h00) begin errors++; $display("FAIL oor_rd_addr got %h exp 00", ram_addr); end
    tick(); smp();
    checks++; if (cpu_wait !== 1'b0) begin errors++; $display("FAIL oor_rd_done got %b exp 0", cpu_wait); end
    checks++; if (cpu_rdata !== 16'h0000) begin errors++; $display("FAIL oor_rd_data got %h exp 0000", cpu_rdata); end
    tick(); cpu_cmd = MNONE;
    smp();
    checks++; if (mem[0] !== 16'h7777) begin errors++; $display("FAIL oor_mem got %h exp 7777", mem[0]); end
  endtask

  task automatic test_tie_after_cpu();
    tick(); cpu_cmd = MREAD; cpu_addr = 9'h030;
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 9'h040;
    smp();
    tick(); smp();
    checks++; if (ram_addr !== 8'h40) begin errors++; $display("FAIL tl_ldr_wins got %h exp 40", ram_addr); end
    tick(); smp();
    checks++; if (ldr_ack !== 1'b1) begin errors++; $display("FAIL tl_ack got %b exp 1", ldr_ack); end
    checks++; if (cpu_wait !== 1'b1) begin errors++; $display("FAIL tl_wait_t2 got %b exp 1", cpu_wait); end
    tick(); ldr_req = 1'b0;
    smp();
    checks++; if (ram_addr !== 8'h30) begin errors++; $display("FAIL tl_cpu_issue got %h exp 30", ram_addr); end
    checks++; if (cpu_wait !== 1'b1) begin errors++; $display("FAIL tl_wait_t3 got %b exp 1", cpu_wait); end
    tick(); smp();
    checks++; if (cpu_wait !== 1'b0) begin errors++; $display("FAIL tl_cpu_done got %b exp 0", cpu_wait); end
    checks++; if (cpu_rdata !== 16'h3030) begin errors++; $display("FAIL tl_cpu_data got %h exp 3030", cpu_rdata); end
    tick(); cpu_cmd = MNONE;
    smp();
  endtask

  task automatic test_reset_in_issue();
    tick(); ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 9'h007; ldr_wdata = 16'hDEAD;
    smp();
    tick(); reset = 1'b1;
    smp();
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL ri_we got %b exp 0", ram_we); end
    checks++; if (ram_addr !== 8'h07) begin errors++; $display("FAIL ri_addr got %h exp 07", ram_addr); end
    tick(); reset = 1'b0; ldr_req = 1'b0; ldr_we = 1'b0; ldr_wdata = 16'h0000;
    smp();
    checks++; if (ldr_ack !== 1'b0) begin errors++; $display("FAIL ri_ack got %b exp 0", ldr_ack); end
    checks++; if (ram_addr !== 8'h00) begin errors++; $display("FAIL ri_idle_addr got %h exp 00", ram_addr); end
    tick(); smp();
    checks++; if (ldr_ack !== 1'b0) begin errors++; $display("FAIL ri_ack_late got %b exp 0", ldr_ack); end
    checks++; if (mem[7] !== 16'h1111) begin errors++; $display("FAIL ri_mem got %h exp 1111", mem[7]); end
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1;
    cpu_cmd = MNONE; cpu_addr = '0; cpu_wdata = '0;
    ldr_req = 1'b0; ldr_we = 1'b0; ldr_addr = '0; ldr_wdata = '0;
    pre_we = 1'b0; pre_a = '0; pre_d = '0;
    preload(8'h12, 16'hBEEF);
    preload(8'h30, 16'h3030);
    preload(8'h40, 16'h4040);
    preload(8'h50, 16'h5050);
    preload(8'h00, 16'h7777);
    preload(8'h07, 16'h1111);
    preload(8'h05, 16'h0000);
    preload(8'h20, 16'h0000);
    test_reset();
    test_cpu_read();
    test_ldr_wr_rd();
    test_contention();
    test_stream();
    test_out_of_range();
    test_tie_after_cpu();
    test_reset_in_issue();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
